// File: rtl/lsu_mem_port.sv
// Load/store unit memory port.
// Converts one RV32I load/store request into one or two word-aligned memory
// accesses. A misaligned access that crosses a word boundary is split into a
// low-word access (ACC1) and a high-word access (ACC2). Loads are reassembled
// from the captured words and then sign- or zero-extended. Stores drive byte
// lanes directly. The memory port outputs are combinational from the state and
// the latched request. All response outputs and req_ready are registered.

module lsu_mem_port (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic [31:0] Data_addr,
  output logic [31:0] Wdata,
  output logic [3:0]  we,
  input  logic [31:0] Rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_split
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic        we_r;
  logic [2:0]  funct3_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] lo_r;
  logic [31:0] hi_r;
  logic        split_r;
  logic        req_ready_r;
  logic        rsp_valid_r;
  logic [31:0] rsp_rdata_r;
  logic        rsp_err_r;
  logic        rsp_split_r;

  logic [1:0]  off_s;
  logic [7:0]  mask_s;
  logic        illegal_s;
  logic        split_s;
  logic [4:0]  sh_lo_s;
  logic [5:0]  sh_hi_s;
  logic [31:0] load_s;
  logic [31:0] data_addr_s;
  logic [31:0] wdata_s;
  logic [3:0]  we_s;

  // Byte mask for the access size before shifting by the byte offset.
  function automatic logic [7:0] base_mask(input logic [1:0] size_code);
    logic [7:0] m;
    case (size_code)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  // Align the {hi,lo} word pair to the byte offset, then extend to 32 bits.
  function automatic logic [31:0] load_extend(input logic [63:0] pair,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [63:0] sh;
    logic [31:0] ext;
    sh = pair >> {off, 3'b000};
    case (f3[1:0])
      2'b00:   ext = f3[2] ? {24'h000000, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   ext = f3[2] ? {16'h0000, sh[15:0]}   : {{16{sh[15]}}, sh[15:0]};
      2'b10:   ext = sh[31:0];
      default: ext = 32'h00000000;
    endcase
    return ext;
  endfunction

  // Decode the latched request: offset, lane mask, legality and split.
  always_comb begin
    off_s     = addr_r[1:0];
    mask_s    = base_mask(funct3_r[1:0]) << off_s;
    illegal_s = (funct3_r[1:0] == 2'b11) || (we_r && funct3_r[2]);
    split_s   = (mask_s[7:4] != 4'h0);
    sh_lo_s   = {off_s, 3'b000};
    sh_hi_s   = 6'd32 - {1'b0, off_s, 3'b000};
    load_s    = load_extend({hi_r, lo_r}, off_s, funct3_r);
  end

  // Next-state logic and combinational memory port drive.
  always_comb begin
    state_s     = state_r;
    data_addr_s = 32'h00000000;
    wdata_s     = 32'h00000000;
    we_s        = 4'h0;
    case (state_r)
      IDLE: begin
        if (req_valid && req_ready_r) begin
          state_s = ACC1;
        end else begin
          state_s = IDLE;
        end
      end
      ACC1: begin
        data_addr_s = {addr_r[31:2], 2'b00};
        wdata_s     = wdata_r << sh_lo_s;
        if (we_r && !illegal_s) begin
          we_s = mask_s[3:0];
        end else begin
          we_s = 4'h0;
        end
        if (illegal_s) begin
          state_s = RESP;
        end else if (split_s) begin
          state_s = ACC2;
        end else begin
          state_s = RESP;
        end
      end
      ACC2: begin
        data_addr_s = {addr_r[31:2], 2'b00} + 32'd4;
        wdata_s     = wdata_r >> sh_hi_s;
        if (we_r) begin
          we_s = mask_s[7:4];
        end else begin
          we_s = 4'h0;
        end
        state_s = RESP;
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register, request latch, load buffers and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      we_r        <= 1'b0;
      funct3_r    <= 3'b000;
      addr_r      <= 32'h00000000;
      wdata_r     <= 32'h00000000;
      lo_r        <= 32'h00000000;
      hi_r        <= 32'h00000000;
      split_r     <= 1'b0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h00000000;
      rsp_err_r   <= 1'b0;
      rsp_split_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      req_ready_r <= (state_s == IDLE);
      rsp_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready_r) begin
            we_r     <= req_we;
            funct3_r <= req_funct3;
            addr_r   <= req_addr;
            wdata_r  <= req_wdata;
            lo_r     <= 32'h00000000;
            hi_r     <= 32'h00000000;
            split_r  <= 1'b0;
          end
        end
        ACC1: begin
          if (!we_r) begin
            lo_r <= Rdata;
          end
        end
        ACC2: begin
          split_r <= 1'b1;
          if (!we_r) begin
            hi_r <= Rdata;
          end
        end
        RESP: begin
          rsp_valid_r <= 1'b1;
          rsp_err_r   <= illegal_s;
          rsp_split_r <= split_r;
          rsp_rdata_r <= (we_r || illegal_s) ? 32'h00000000 : load_s;
        end
        default: begin
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign Data_addr = data_addr_s;
  assign Wdata     = wdata_s;
  assign we        = we_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_split = rsp_split_r;

endmodule

// File: doc/lsu_mem_port.md
LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 SHALL have one clock and an asynchronous active-high reset: clk  in  1  rising-edge clock; rst  in  1  async active-high reset.
REQ-002 SHALL provide request inputs:
- req_valid  in  1  request present
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32I width/sign code
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
REQ-003 SHALL provide req_ready  out  1, high only in IDLE.
REQ-004 SHALL provide the memory-side ports:
- Data_addr  out  32  word-aligned address
- Wdata  out  32  lane-shifted write data
- we  out  4  byte-lane write enables
- Rdata  in  32  combinational read word, valid in the same cycle as Data_addr
REQ-005 SHALL provide response outputs:
- rsp_valid  out  1  one-cycle pulse
- rsp_rdata  out  32  extended load data, 0 for stores
- rsp_err  out  1  illegal funct3
- rsp_split  out  1  access crossed a word boundary

Function
REQ-006 SHALL use an FSM with states IDLE, ACC1, ACC2, RESP.
REQ-007 In IDLE, req_valid&&req_ready SHALL latch all req_* fields and go to ACC1; with req_valid=0 it SHALL stay in IDLE.
REQ-008 SHALL decode size from funct3[1:0]: 00=1B, 01=2B, 10=4B; funct3[2]=1 means zero-extend (loads only).
REQ-009 SHALL treat funct3[1:0]=11, or a store with funct3[2]=1, as illegal: ACC1 goes directly to RESP, we=0 throughout, rsp_err=1, rsp_rdata=0.
REQ-010 SHALL compute the byte offset off=addr[1:0] and the 8-bit mask m=(0x01/0x03/0x0F for size 1/2/4)<<off.
REQ-011 ACC1 SHALL drive:
- Data_addr = addr & 0xFFFFFFFC
- we = m[3:0] for stores, 0 for loads
- Wdata = wdata<<(8*off)
REQ-012 In ACC1 for loads, Rdata SHALL be captured into buffer lo.
REQ-013 When m[7:4]!=0 the access is split: ACC1 SHALL go to ACC2, otherwise to RESP.
REQ-014 ACC2 SHALL drive:
- Data_addr = (addr & 0xFFFFFFFC)+4, modulo 2^32 (0xFFFFFFFC wraps to 0)
- we = m[7:4] for stores
- Wdata = wdata>>(8*(4-off))
REQ-015 In ACC2 for loads, Rdata SHALL be captured into buffer hi.
REQ-016 For a load that does not split, hi SHALL be treated as 0.
REQ-017 RESP SHALL assert rsp_valid for exactly one cycle, then return to IDLE; rsp_split=1 iff ACC2 was visited.
REQ-018 Load data SHALL be formed as sel=({hi,lo}>>(8*off))[8*size-1:0], then sign-extended if funct3[2]=0, zero-extended otherwise, into rsp_rdata.
REQ-019 Latency from the accept edge SHALL be: rsp_valid high 2 cycles later for aligned/non-split or illegal accesses, 3 cycles later for split accesses.
REQ-020 Throughput SHALL be at most one request per 3 cycles non-split and per 4 cycles split; req_ready SHALL be 0 in ACC1/ACC2/RESP.
REQ-021 Outside ACC1/ACC2, Data_addr, Wdata and we SHALL be 0; we SHALL never be nonzero for loads.
REQ-022 All outputs other than the combinationally derived memory port SHALL be registered.

Reset
REQ-023 rst=1 SHALL asynchronously force state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_split=0, buffers=0, we=0, Data_addr=0, Wdata=0, req_ready=1 while deasserted-IDLE.
REQ-024 Reset during ACC1 SHALL abandon the request; no second-half write (ACC2) SHALL occur and no response SHALL be produced.
REQ-025 Reset during ACC2 SHALL immediately deassert we; a first-half store already written remains in memory.

Verification
REQ-026 SW addr 0x100 wdata 0xDEADBEEF -> ACC1 Data_addr=0x100 we=1111 Wdata=0xDEADBEEF; rsp_valid 2 cycles after accept, rsp_split=0.
REQ-027 SB addr 0x203 wdata 0x000000A5 -> we=1000 Wdata=0xA5000000; LB same addr -> rsp_rdata=0xFFFFFFA5; LBU -> 0x000000A5.
REQ-028 SW addr 0x302, mem[0x300]=0x44332211 and mem[0x304]=0x88776655 before write, wdata 0xCAFEF00D -> ACC1 we=1100 Wdata=0xF00D0000, ACC2 Data_addr=0x304 we=0011 Wdata=0x0000CAFE; subsequent LW 0x302 -> 0xCAFEF00D, rsp_split=1, 3-cycle latency.
REQ-029 LH addr 0x1FF, bytes 0x1FF=0x34, 0x200=0x92 -> rsp_rdata=0xFFFF9234, rsp_split=1; LHU -> 0x00009234.
REQ-030 funct3=011 load and funct3=100 store -> rsp_err=1, rsp_rdata=0, we=0 all cycles; LW addr 0xFFFFFFFE -> ACC2 Data_addr=0x00000000.
REQ-031 Split SW at 0x302 with rst pulsed during ACC2 -> we=0 immediately, rsp_valid never asserted, req_ready=1 after release.
